// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory request/ack bus between fetch unit and memory
interface instr_fetch_unit_if #(
    parameter int PC_W = 64
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            imem_ack;

    // Fetch unit drives the request side
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    // Memory answers with data and an ack strobe
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and fetch/issue sequencer feeding the control unit
module instr_fetch_unit #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instr_fetch_unit_if.master   imem,
    input  logic                 stall,
    input  logic                 bus_pcSrc,
    input  logic [PC_W-1:0]      br_offset,
    output logic [31:0]          instr,
    output logic [10:0]          opcode,
    output logic [PC_W-1:0]      pc_out,
    output logic                 instr_valid,
    output logic [CNT_W-1:0]     retired_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               req_q, req_d;
    logic [PC_W-1:0]    addr_q, addr_d;
    logic [31:0]        instr_q, instr_d;
    logic [PC_W-1:0]    pc_out_q, pc_out_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PC_W-1:0]    next_pc;

    // Next-state and register updates for the IDLE -> FETCH -> ISSUE loop
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = req_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        // Branch offset is in words; bits shifted past PC_W are dropped
        next_pc  = bus_pcSrc ? (pc_out_q + (br_offset << 2)) : (pc_out_q + PC_W'(4));

        unique case (state_q)
            IDLE: begin
                req_d   = 1'b1;
                addr_d  = pc_q;
                state_d = FETCH;
            end
            FETCH: begin
                // Ack only counts while a request is actually outstanding
                if (req_q && imem.imem_ack) begin
                    instr_d  = imem.imem_rdata;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    req_d    = 1'b0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // Stall freezes the issued instruction; branch inputs ignored
                if (!stall) begin
                    pc_d    = next_pc;
                    addr_d  = next_pc;
                    req_d   = 1'b1;
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign instr          = instr_q;
    assign opcode         = instr_q[31:21];
    assign pc_out         = pc_out_q;
    assign instr_valid    = valid_q;
    assign retired_cnt    = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
    localparam int PC_W  = 64;
    localparam int CNT_W = 32;
    localparam logic [31:0] ADD_I = 32'h8B000000;
    localparam logic [31:0] SUB_I = 32'hCB000000;
    localparam logic [31:0] B_I   = 32'h14000000;

    logic              clk;
    logic              rst_n;
    logic              stall;
    logic              bus_pcSrc;
    logic [PC_W-1:0]   br_offset;
    logic [31:0]       instr;
    logic [10:0]       opcode;
    logic [PC_W-1:0]   pc_out;
    logic              instr_valid;
    logic [CNT_W-1:0]  retired_cnt;

    int n_total;
    int n_pass;

    instr_fetch_unit_if #(.PC_W(PC_W)) bus ();

    instr_fetch_unit #(.PC_W(PC_W), .RESET_PC('0), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus),
        .stall       (stall),
        .bus_pcSrc   (bus_pcSrc),
        .br_offset   (br_offset),
        .instr       (instr),
        .opcode      (opcode),
        .pc_out      (pc_out),
        .instr_valid (instr_valid),
        .retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        bus_pcSrc = 1'b0;
        br_offset = '0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;

        // Reset state
        #12;
        check("rst_req", 64'(bus.imem_req), 64'd0);
        check("rst_addr", bus.imem_addr, 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_cnt", 64'(retired_cnt), 64'd0);
        check("rst_pc_out", pc_out, 64'd0);

        // Sequential fetch: ADD at 0, SUB at 4
        cyc(); rst_n = 1'b1;
        cyc();
        check("seq_req0", 64'(bus.imem_req), 64'd1);
        check("seq_addr0", bus.imem_addr, 64'd0);
        bus.imem_ack = 1'b1; bus.imem_rdata = ADD_I;
        cyc();
        check("seq_valid0", 64'(instr_valid), 64'd1);
        check("seq_opc0", 64'(opcode), 64'(11'b10001011000));
        check("seq_pc0", pc_out, 64'd0);
        check("seq_req_issue", 64'(bus.imem_req), 64'd0);
        bus.imem_ack = 1'b0;
        cyc();
        check("seq_addr1", bus.imem_addr, 64'd4);
        check("seq_valid_drop", 64'(instr_valid), 64'd0);
        bus.imem_ack = 1'b1; bus.imem_rdata = SUB_I;
        cyc();
        check("seq_opc1", 64'(opcode), 64'(11'b11001011000));
        check("seq_pc1", pc_out, 64'd4);
        bus.imem_ack = 1'b0;
        cyc();
        check("seq_addr2", bus.imem_addr, 64'd8);
        check("seq_cnt2", 64'(retired_cnt), 64'd2);

        // Branch taken from 8 with offset -2 words
        bus.imem_ack = 1'b1; bus.imem_rdata = B_I;
        cyc();
        check("br_pc", pc_out, 64'd8);
        check("br_valid", 64'(instr_valid), 64'd1);
        bus.imem_ack = 1'b0; bus_pcSrc = 1'b1; br_offset = 64'hFFFF_FFFF_FFFF_FFFE;
        cyc();
        check("br_addr", bus.imem_addr, 64'd0);
        check("br_gap", 64'(instr_valid), 64'd0);
        bus_pcSrc = 1'b0; br_offset = '0;
        bus.imem_ack = 1'b1; bus.imem_rdata = ADD_I;
        cyc();
        check("br_valid_back", 64'(instr_valid), 64'd1);
        check("br_cnt", 64'(retired_cnt), 64'd3);

        // Stall hold for 5 cycles with bus_pcSrc toggling
        bus.imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            stall = 1'b1;
            bus_pcSrc = i[0];
            br_offset = 64'd100;
            cyc();
            check("stall_instr", 64'(instr), 64'(ADD_I));
            check("stall_pc", pc_out, 64'd0);
            check("stall_cnt", 64'(retired_cnt), 64'd3);
            check("stall_req", 64'(bus.imem_req), 64'd0);
        end
        stall = 1'b0; bus_pcSrc = 1'b0; br_offset = '0;
        cyc();
        check("stall_release_cnt", 64'(retired_cnt), 64'd4);
        check("stall_release_addr", bus.imem_addr, 64'd4);

        // Slow memory: ack after 3 waiting cycles, 4 FETCH cycles total
        for (int i = 0; i < 3; i++) begin
            check("slow_req", 64'(bus.imem_req), 64'd1);
            check("slow_addr", bus.imem_addr, 64'd4);
            cyc();
        end
        check("slow_req_last", 64'(bus.imem_req), 64'd1);
        check("slow_addr_last", bus.imem_addr, 64'd4);
        check("slow_not_valid", 64'(instr_valid), 64'd0);
        bus.imem_ack = 1'b1; bus.imem_rdata = SUB_I;
        cyc();
        check("slow_instr", 64'(instr), 64'(SUB_I));
        // Spurious ack during ISSUE
        bus.imem_rdata = 32'hDEADBEEF; stall = 1'b1;
        cyc();
        check("spur_instr", 64'(instr), 64'(SUB_I));
        check("spur_req", 64'(bus.imem_req), 64'd0);
        check("spur_valid", 64'(instr_valid), 64'd1);
        stall = 1'b0; bus.imem_ack = 1'b0;
        cyc();
        check("spur_addr", bus.imem_addr, 64'd8);
        check("spur_cnt", 64'(retired_cnt), 64'd5);

        // Wrap-around: branch to 2^64-4, then sequential to 0
        bus.imem_ack = 1'b1; bus.imem_rdata = ADD_I;
        cyc();
        bus.imem_ack = 1'b0; bus_pcSrc = 1'b1; br_offset = 64'hFFFF_FFFF_FFFF_FFFD;
        cyc();
        check("wrap_br_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        bus_pcSrc = 1'b0; br_offset = '0; bus.imem_ack = 1'b1;
        cyc();
        check("wrap_pc_out", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        bus.imem_ack = 1'b0;
        cyc();
        check("wrap_addr", bus.imem_addr, 64'd0);
        check("wrap_cnt", 64'(retired_cnt), 64'd7);

        // Async reset while a fetch is pending
        #2 rst_n = 1'b0;
        #1;
        check("arst_req", 64'(bus.imem_req), 64'd0);
        check("arst_addr", bus.imem_addr, 64'd0);
        check("arst_valid", 64'(instr_valid), 64'd0);
        check("arst_instr", 64'(instr), 64'd0);
        check("arst_pc_out", pc_out, 64'd0);
        check("arst_cnt", 64'(retired_cnt), 64'd0);
        bus.imem_ack = 1'b1; bus.imem_rdata = SUB_I;
        cyc(); rst_n = 1'b1;
        cyc();
        check("arst_idle_ack_ignored", 64'(instr_valid), 64'd0);
        check("arst_restart_req", 64'(bus.imem_req), 64'd1);
        check("arst_restart_addr", bus.imem_addr, 64'd0);
        cyc();
        check("arst_refetch_valid", 64'(instr_valid), 64'd1);
        check("arst_refetch_instr", 64'(instr), 64'(SUB_I));
        check("arst_refetch_pc", pc_out, 64'd0);
        bus.imem_ack = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
